// File: rtl/cluster_serializer.sv
// Captures eight candidate clusters per load strobe and drains the valid
// ones in slot order through a valid/ready port with SOF/EOF marking.
module cluster_serializer #(
  parameter int MAX_ADR = 1536,
  parameter int OVF_W   = 8
) (
  input  logic             clock4x,
  input  logic             global_reset_n,
  input  logic             load,
  input  logic [10:0]      adr0,
  input  logic [10:0]      adr1,
  input  logic [10:0]      adr2,
  input  logic [10:0]      adr3,
  input  logic [10:0]      adr4,
  input  logic [10:0]      adr5,
  input  logic [10:0]      adr6,
  input  logic [10:0]      adr7,
  input  logic [2:0]       cnt0,
  input  logic [2:0]       cnt1,
  input  logic [2:0]       cnt2,
  input  logic [2:0]       cnt3,
  input  logic [2:0]       cnt4,
  input  logic [2:0]       cnt5,
  input  logic [2:0]       cnt6,
  input  logic [2:0]       cnt7,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [10:0]      out_adr,
  output logic [2:0]       out_cnt,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic [3:0]       set_ncl,
  output logic             ovf_pulse,
  output logic [OVF_W-1:0] ovf_cnt
);

  localparam logic [10:0] MaxAdr = 11'(MAX_ADR);

  logic [10:0] adr_in [8];
  logic [2:0]  cnt_in [8];
  logic [10:0] adr_q  [8];
  logic [2:0]  cnt_q  [8];

  logic [7:0]       pending_q, pending_d;
  logic             first_q, first_d;
  logic             out_valid_q, out_valid_d;
  logic [10:0]      out_adr_q, out_adr_d;
  logic [2:0]       out_cnt_q, out_cnt_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic [3:0]       set_ncl_q, set_ncl_d;
  logic             ovf_pulse_q, ovf_pulse_d;
  logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

  logic       accept;
  logic       drop;
  logic       advance;
  logic [7:0] valid_in;
  logic [3:0] ncl;
  logic [2:0] k;

  assign adr_in = '{adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7};
  assign cnt_in = '{cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7};

  always_comb begin
    accept   = load && (pending_q == 8'd0);
    drop     = load && (pending_q != 8'd0);
    advance  = !out_valid_q || out_ready;
    valid_in = '0;
    ncl      = '0;
    for (int i = 0; i < 8; i++) begin
      valid_in[i] = adr_in[i] < MaxAdr;
      ncl         = ncl + {3'd0, valid_in[i]};
    end
    // Descending scan leaves k at the lowest pending slot
    k = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) k = 3'(i);
    end
  end

  always_comb begin
    pending_d   = pending_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_adr_d   = out_adr_q;
    out_cnt_d   = out_cnt_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    set_ncl_d   = set_ncl_q;
    ovf_pulse_d = drop;
    ovf_cnt_d   = ovf_cnt_q;
    if (advance) begin
      if (pending_q != 8'd0) begin
        out_valid_d  = 1'b1;
        out_adr_d    = adr_q[k];
        out_cnt_d    = cnt_q[k];
        out_sof_d    = first_q;
        out_eof_d    = (pending_q & ~(8'd1 << k)) == 8'd0;
        pending_d[k] = 1'b0;
        first_d      = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (accept) begin
      pending_d = valid_in;
      first_d   = 1'b1;
      set_ncl_d = ncl;
    end
    if (drop && !(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      pending_q   <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_adr_q   <= '0;
      out_cnt_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      set_ncl_q   <= '0;
      ovf_pulse_q <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      pending_q   <= pending_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_adr_q   <= out_adr_d;
      out_cnt_q   <= out_cnt_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      set_ncl_q   <= set_ncl_d;
      ovf_pulse_q <= ovf_pulse_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // Slot payload needs no reset; pending qualifies it
  always_ff @(posedge clock4x) begin
    if (accept) begin
      for (int i = 0; i < 8; i++) begin
        adr_q[i] <= adr_in[i];
        cnt_q[i] <= cnt_in[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_adr   = out_adr_q;
  assign out_cnt   = out_cnt_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign busy      = pending_q != 8'd0;
  assign set_ncl   = set_ncl_q;
  assign ovf_pulse = ovf_pulse_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule
